// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done
// handshake, registered quotient/remainder, and a one-cycle divide-by-zero path.
module seq_divider #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // ZERO is the one-cycle pending state of the divide-by-zero path; busy stays low there.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH:0]   r, r_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] d, d_next;
  logic [CW-1:0]    cnt, cnt_next;

  logic             busy_next, done_next, dbz_next;
  logic [WIDTH-1:0] quot_next, rem_next;

  logic [WIDTH:0]   r_shift, d_inv, trial;

  // Trial subtraction as add of the inverted divisor plus one; trial[WIDTH] is the borrow.
  always_comb begin
    r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
    d_inv   = ~{1'b0, d};
    trial   = r_shift + d_inv + ONE;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next = state;
    r_next     = r;
    q_next     = q;
    d_next     = d;
    cnt_next   = cnt;
    done_next  = 1'b0;
    quot_next  = quotient;
    rem_next   = remainder;
    dbz_next   = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          q_next     = dividend;
          d_next     = divisor;
          r_next     = '0;
          cnt_next   = CW'(WIDTH);
          state_next = (divisor != '0) ? RUN : ZERO;
        end
      end

      RUN: begin
        r_next   = trial[WIDTH] ? r_shift : trial;
        q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          quot_next  = q_next;
          rem_next   = r_next[WIDTH-1:0];
          dbz_next   = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      ZERO: begin
        // q still holds the captured dividend, which becomes the remainder.
        quot_next  = '1;
        rem_next   = q;
        dbz_next   = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state       <= state_next;
      r           <= r_next;
      q           <= q_next;
      d           <= d_next;
      cnt         <= cnt_next;
      busy        <= busy_next;
      done        <= done_next;
      quotient    <= quot_next;
      remainder   <= rem_next;
      div_by_zero <= dbz_next;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed vectors, handshake timing,
// ignored/back-to-back requests, mid-run reset and a full operand sweep.
module tb_seq_divider;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             clk_en = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int compared = 0;
  int mismatched = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns 1 ns after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
  endtask

  // Counts edges from the accept edge until done, and busy samples before done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    forever begin
      busy_cnt += int'(busy);
      tick();
      lat++;
      if (done) break;
      if (lat >= 20) begin
        check("done_timeout", 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic edz);
    int lat, bc;
    int exp_lat;
    exp_lat = edz ? 1 : WIDTH;
    issue(a, b);
    wait_done(lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bc), edz ? 32'd0 : 32'(WIDTH));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, quiet;

    // Asynchronous reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    #5 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Normal case and edge values.
    run_op("d23_5", 5'd23, 5'd5, 5'd4, 5'd3, 1'b0);
    run_op("d31_1", 5'd31, 5'd1, 5'd31, 5'd0, 1'b0);
    run_op("d7_9", 5'd7, 5'd9, 5'd0, 5'd7, 1'b0);
    run_op("d31_31", 5'd31, 5'd31, 5'd1, 5'd0, 1'b0);

    // Divide by zero, then a normal op clears the flag.
    run_op("d13_0", 5'd13, 5'd0, 5'h1F, 5'd13, 1'b1);
    run_op("d10_3", 5'd10, 5'd3, 5'd3, 5'd1, 1'b0);

    // Start while busy is ignored.
    issue(5'd20, 5'd3);
    tick();
    start = 1'b1; dividend = 5'd9; divisor = 5'd2;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("busy_ign_lat", 32'(lat + 2), 32'd5);
    check("busy_ign_q", 32'(quotient), 32'd6);
    check("busy_ign_r", 32'(remainder), 32'd2);

    // Back-to-back: start held during the done cycle; outputs hold until next done.
    start = 1'b1; dividend = 5'd9; divisor = 5'd2;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      check("hold_q", 32'(quotient), 32'd6);
      check("hold_r", 32'(remainder), 32'd2);
      tick();
      lat++;
    end
    check("b2b_spacing", 32'(lat), 32'd6);
    check("b2b_q", 32'(quotient), 32'd4);
    check("b2b_r", 32'(remainder), 32'd1);
    tick();
    check("b2b_done_pulse", 32'(done), 32'd0);

    // Reset during the third RUN cycle aborts the operation.
    issue(5'd25, 5'd4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    quiet = 0;
    repeat (8) begin
      tick();
      quiet += int'(done) + int'(busy);
    end
    check("abort_no_done", 32'(quiet), 32'd0);
    run_op("d25_4", 5'd25, 5'd4, 5'd6, 5'd1, 1'b0);

    // Full operand sweep against the language's own divide/modulo.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        if (b == 0)
          run_op($sformatf("sw%0d_%0d", a, b), 5'(a), 5'(b), 5'h1F, 5'(a), 1'b1);
        else begin
          run_op($sformatf("sw%0d_%0d", a, b), 5'(a), 5'(b), 5'(a / b), 5'(a % b), 1'b0);
          check($sformatf("inv%0d_%0d", a, b), 32'(int'(quotient) * b + int'(remainder)), 32'(a));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the 5-bit datapath, the inverse companion to the registered 5-bit carry-lookahead adder. It takes a dividend and divisor through a start/done handshake and computes one quotient bit per cycle with a trial subtraction (add of inverted divisor plus one). Quotient and remainder are returned in registers. It sits beside the adder in the arithmetic unit and shares its single clock domain.

## Interface
- WIDTH, 5, operand, quotient and remainder width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  single-cycle pulse; results valid in the same cycle.
- quotient  output  WIDTH  registered quotient; holds until the next done.
- remainder  output  WIDTH  registered remainder; holds until the next done.
- div_by_zero  output  1  set with done when divisor was 0; holds until the next done.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating; busy=1.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient and remainder all go to 0.
  - The internal partial remainder, shift register and counter are cleared.
- Accept: in IDLE with start=1 at a clock edge:
  - Capture dividend into the shift register (Q) and divisor into D.
  - Clear the partial remainder R, which is WIDTH+1 bits.
  - Load the counter with WIDTH.
  - If the divisor is nonzero, go to RUN. If it is zero, take the zero path below.
- Iteration, once per RUN edge:
  - Shift left: R' = {R[WIDTH-1:0], Q[WIDTH-1]}, Q' = {Q[WIDTH-2:0], 0}.
  - Trial: T = R' + ~{0,D} + 1, computed at WIDTH+1 bits.
  - No borrow (T[WIDTH]=0): R = T and Q[0] = 1.
  - Borrow: R = R' and Q[0] = 0.
  - The counter decrements by 1.
- Completion: on the iteration edge where the counter goes 1→0:
  - quotient = final Q and remainder = final R[WIDTH-1:0].
  - div_by_zero = 0, done = 1.
  - State returns to IDLE.
- Divisor zero: on the accept edge the block takes no iterations and does not enter RUN. At the next edge:
  - quotient = all ones (5'h1F) and remainder = dividend.
  - div_by_zero = 1, done = 1.
- Ignored requests:
  - start while busy: no effect, operands not recaptured.
  - start while the zero path is pending: no effect.
- Back-to-back: start may be high in the same cycle done is high. That start is accepted at the following edge.
- Reset during RUN: the operation is aborted with no done pulse, and quotient/remainder return to 0.
- Invariants:
  - For nonzero divisor: quotient*divisor + remainder = dividend and remainder < divisor.
  - quotient, remainder and div_by_zero change only on a done edge or on reset.

## Timing
- Accept edge E: busy rises after E.
- Nonzero divisor:
  - Iterations occur on edges E+1 … E+WIDTH.
  - done is high for exactly one cycle following edge E+WIDTH (E+5 at default), and busy falls at that same edge.
  - Latency from the accept edge to results is WIDTH cycles.
  - Minimum start-to-start spacing is WIDTH+1 cycles.
- Zero divisor:
  - done is high for the cycle following E+1, so latency is 1 cycle.
  - busy never asserts.
- done is never high for two consecutive cycles.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Reset: pulse rst_n low with no clock running → all outputs read 0 immediately; after release, state is IDLE and busy=0.
- Normal case: dividend=23, divisor=5 → done 5 cycles after the accept edge, quotient=4, remainder=3, div_by_zero=0, busy high for exactly 5 cycles.
- Edge values:
  - 31/1 → quotient=31, remainder=0.
  - 7/9 → quotient=0, remainder=7.
  - 31/31 → quotient=1, remainder=0.
  - Exhaustive sweep of all 1024 operand pairs checks the invariant against a reference model.
- Divide by zero: 13/0 → done 1 cycle after accept, quotient=5'h1F, remainder=13, div_by_zero=1, busy stays 0; a following 10/3 clears div_by_zero (quotient=3, remainder=1).
- Start while busy, back-to-back, and hold:
  - Start 20/3, then pulse start with 9/2 two cycles later → the second request is ignored; result is quotient=6, remainder=2.
  - Start 9/2 held high during the done cycle → accepted; quotient=4, remainder=1 exactly 6 cycles after the first done.
  - Outputs hold their values between the two done pulses.
- Reset mid-operation: assert rst_n during the 3rd RUN cycle of 25/4 → no done pulse, outputs 0; a fresh 25/4 afterwards yields quotient=6, remainder=1.
